// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand-in / result-out handshake bundle for alu_pipe
// Purpose : groups the issue stream (in_*) and result stream (out_*) of the ALU.
// Ports   : master = upstream issuer and result sink; slave = the ALU itself.
//           in_valid/in_ready/in_op/in_s/in_a/in_b/in_sh_c   operation offered
//           out_valid/out_ready/out_result/out_wr/out_flags  result returned
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic             in_s;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sh_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_wr;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_op, in_s, in_a, in_b, in_sh_c, out_ready,
        input  in_ready, out_valid, out_result, out_wr, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_s, in_a, in_b, in_sh_c, out_ready,
        output in_ready, out_valid, out_result, out_wr, out_flags
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ARM data-processing ALU with NZCV flags
// Purpose : executes the 16 ARM data-processing opcodes behind a valid/ready
//           handshake and owns the architectural NZCV register.
// Ports   : clk, rst_n (async active-low), flush (sync drop of in-flight ops)
//           bus        alu_pipe_if.slave operand/result streams
//           flag_we    external NZCV write strobe, flag_wdata its value
//           flags_q    current architectural NZCV
module alu_pipe #(
    parameter int         WIDTH      = 32,
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    alu_pipe_if.slave     bus,
    input  logic          flag_we,
    input  logic [3:0]    flag_wdata,
    output logic [3:0]    flags_q
);
    // Stage 1: captured operation
    logic             s1_valid_q;
    logic [3:0]       s1_op_q;
    logic             s1_s_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_sh_c_q;

    // Stage 2: registered result, drives the output stream directly
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_result_q;
    logic             s2_wr_q;
    logic [3:0]       s2_flags_q;

    logic             s2_load;
    logic             in_ready_d;
    logic             accept;

    // Combinational execute
    logic             is_test;
    logic             s_eff;
    logic             arith;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flags_d;
    logic [3:0]       out_flags_d;

    assign s2_load    = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign in_ready_d = ~s1_valid_q | s2_load;
    assign accept     = bus.in_valid & in_ready_d;

    // TST/TEQ/CMP/CMN (8..B) always set flags and never write back
    assign is_test = (s1_op_q[3:2] == 2'b10);
    assign s_eff   = s1_s_q | is_test;

    always_comb begin
        x        = '0;
        y        = '0;
        cin      = 1'b0;
        arith    = 1'b0;
        result_d = '0;
        case (s1_op_q)
            4'h0, 4'h8: result_d = s1_a_q & s1_b_q;
            4'h1, 4'h9: result_d = s1_a_q ^ s1_b_q;
            4'h2, 4'hA: begin arith = 1'b1; x = s1_a_q; y = ~s1_b_q; cin = 1'b1;       end
            4'h3:       begin arith = 1'b1; x = s1_b_q; y = ~s1_a_q; cin = 1'b1;       end
            4'h4, 4'hB: begin arith = 1'b1; x = s1_a_q; y = s1_b_q;  cin = 1'b0;       end
            4'h5:       begin arith = 1'b1; x = s1_a_q; y = s1_b_q;  cin = flags_q[1]; end
            4'h6:       begin arith = 1'b1; x = s1_a_q; y = ~s1_b_q; cin = flags_q[1]; end
            4'h7:       begin arith = 1'b1; x = s1_b_q; y = ~s1_a_q; cin = flags_q[1]; end
            4'hC:       result_d = s1_a_q | s1_b_q;
            4'hD:       result_d = s1_b_q;
            4'hE:       result_d = s1_a_q & ~s1_b_q;
            default:    result_d = ~s1_b_q;
        endcase
        // Subtracts are folded into additions of the inverted operand, so the
        // carry-out is already NOT borrow.
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        if (arith) begin
            result_d = sum[WIDTH-1:0];
        end
        flags_d[3] = result_d[WIDTH-1];
        flags_d[2] = (result_d == '0);
        flags_d[1] = arith ? sum[WIDTH] : s1_sh_c_q;
        flags_d[0] = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (result_d[WIDTH-1] != x[WIDTH-1]))
                           : flags_q[0];
        out_flags_d = s_eff ? flags_d : flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_s_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sh_c_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_wr_q     <= 1'b0;
            s2_flags_q  <= '0;
            flags_q     <= FLAG_RESET;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (accept) begin
                s1_valid_q <= 1'b1;
                s1_op_q    <= bus.in_op;
                s1_s_q     <= bus.in_s;
                s1_a_q     <= bus.in_a;
                s1_b_q     <= bus.in_b;
                s1_sh_c_q  <= bus.in_sh_c;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end

            if (flush) begin
                s2_valid_q <= 1'b0;
            end else if (s2_load) begin
                s2_valid_q  <= 1'b1;
                s2_result_q <= result_d;
                s2_wr_q     <= ~is_test;
                s2_flags_q  <= out_flags_d;
            end else if (bus.out_ready) begin
                s2_valid_q <= 1'b0;
            end

            // An MSR-style write overrides the pipeline's own update that cycle
            if (flag_we) begin
                flags_q <= flag_wdata;
            end else if (s2_load && s_eff && !flush) begin
                flags_q <= flags_d;
            end
        end
    end

    assign bus.in_ready   = in_ready_d;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_wr     = s2_wr_q;
    assign bus.out_flags  = s2_flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe
module tb_alu_pipe;
    typedef struct {
        logic [3:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic        shc;
        logic [31:0] r;
        logic        wr;
        logic [3:0]  f;
    } vec_t;

    localparam logic [3:0] FRST = 4'b0101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       flag_we = 1'b0;
    logic [3:0] flag_wdata = 4'b0000;
    logic [3:0] flags_q;

    int   total = 0;
    int   bad = 0;
    bit   sb_off = 1'b0;
    vec_t exp_v;
    vec_t sbq[$];
    vec_t tbl[17];

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32), .FLAG_RESET(FRST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .flag_we    (flag_we),
        .flag_wdata (flag_wdata),
        .flags_q    (flags_q)
    );

    always #5 clk = ~clk;

    // Scoreboard: push on accept, pop and compare on result handshake
    always @(negedge clk) begin
        vec_t e;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready && !flush && !sb_off) sbq.push_back(exp_v);
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    if (!sb_off) begin
                        total++; bad++;
                        $display("FAIL unexpected_result got=%h", bus.out_result);
                    end
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if (bus.out_result !== e.r || bus.out_wr !== e.wr || bus.out_flags !== e.f) begin
                        bad++;
                        $display("FAIL result op=%h got r=%h wr=%b f=%b exp r=%h wr=%b f=%b",
                                 e.op, bus.out_result, bus.out_wr, bus.out_flags, e.r, e.wr, e.f);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge with in_valid low
    task automatic send(input vec_t v);
        int  n;
        bit  acc;
        bus.in_valid = 1'b1;
        bus.in_op = v.op; bus.in_s = v.s; bus.in_a = v.a; bus.in_b = v.b; bus.in_sh_c = v.shc;
        exp_v = v;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout got=0 exp=accept");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d exp=0", sbq.size());
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input logic shc, input logic [31:0] r,
                                input logic wr, input logic [3:0] f);
        vec_t v;
        v.op = op; v.s = s; v.a = a; v.b = b; v.shc = shc; v.r = r; v.wr = wr; v.f = f;
        return v;
    endfunction

    initial begin
        // Back-to-back chain; each flag expectation depends on the previous row.
        tbl[0]  = mk(4'h4, 1, 32'hFFFFFFFF, 32'h1,        0, 32'h0,        1, 4'b0110); // ADDS
        tbl[1]  = mk(4'h5, 1, 32'h5,        32'h6,        0, 32'hC,        1, 4'b0000); // ADCS C=1
        tbl[2]  = mk(4'h2, 1, 32'h80000000, 32'h1,        0, 32'h7FFFFFFF, 1, 4'b0011); // SUBS
        tbl[3]  = mk(4'h3, 1, 32'h5,        32'h3,        0, 32'hFFFFFFFE, 1, 4'b1000); // RSBS
        tbl[4]  = mk(4'hA, 0, 32'h3,        32'h3,        0, 32'h0,        0, 4'b0110); // CMP
        tbl[5]  = mk(4'hD, 0, 32'h0,        32'h9,        1, 32'h9,        1, 4'b0110); // MOV
        tbl[6]  = mk(4'h0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 1, 4'b1010); // ANDS
        tbl[7]  = mk(4'h9, 0, 32'h1234,     32'h1234,     0, 32'h0,        0, 4'b0100); // TEQ
        tbl[8]  = mk(4'h6, 1, 32'h10,       32'h3,        0, 32'hC,        1, 4'b0010); // SBCS C=0
        tbl[9]  = mk(4'h7, 1, 32'h1,        32'h1,        0, 32'h0,        1, 4'b0110); // RSCS C=1
        tbl[10] = mk(4'hB, 0, 32'h7FFFFFFF, 32'h1,        0, 32'h80000000, 0, 4'b1001); // CMN
        tbl[11] = mk(4'h1, 1, 32'hFFFF0000, 32'h0FF00FF0, 0, 32'hF00F0FF0, 1, 4'b1001); // EORS
        tbl[12] = mk(4'hF, 1, 32'h0,        32'hFFFFFFFF, 1, 32'h0,        1, 4'b0111); // MVNS
        tbl[13] = mk(4'hE, 1, 32'hFF,       32'h0F,       0, 32'hF0,       1, 4'b0001); // BICS
        tbl[14] = mk(4'hC, 0, 32'h1,        32'h2,        0, 32'h3,        1, 4'b0001); // ORR
        tbl[15] = mk(4'h5, 1, 32'h7FFFFFFF, 32'h0,        0, 32'h7FFFFFFF, 1, 4'b0000); // ADCS C=0
        tbl[16] = mk(4'h8, 0, 32'hFF,       32'h100,      1, 32'h0,        0, 4'b0110); // TST

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_s = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_sh_c = 1'b0; bus.out_ready = 1'b1;
        exp_v = mk(0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_wr", 32'(bus.out_wr), 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_flags_q", 32'(flags_q), 32'(FRST));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Latency: result appears on the edge after the accept edge
        send(mk(4'hD, 0, 32'h0, 32'hAB, 0, 32'hAB, 1, FRST));
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        drain();

        for (int i = 0; i < 17; i++) send(tbl[i]);
        drain();
        check("flags_after_table", 32'(flags_q), 32'b0110);

        // External flag write beats the same-cycle ADDS flag update
        send(mk(4'h4, 1, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 1, 4'b0110));
        flag_we = 1'b1; flag_wdata = 4'b1001;
        @(posedge clk);
        #1;
        flag_we = 1'b0;
        check("flag_we_wins", 32'(flags_q), 32'b1001);
        drain();

        // Backpressure: two accepts fill the pipe, then results drain in order
        bus.out_ready = 1'b0;
        send(mk(4'hD, 0, 0, 32'h11, 0, 32'h11, 1, 4'b1001));
        send(mk(4'hD, 0, 0, 32'h22, 0, 32'h22, 1, 4'b1001));
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        fork
            begin
                send(mk(4'hD, 0, 0, 32'h33, 0, 32'h33, 1, 4'b1001));
                send(mk(4'hD, 0, 0, 32'h44, 0, 32'h44, 1, 4'b1001));
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both stages full
        sb_off = 1'b1;
        bus.out_ready = 1'b0;
        send(mk(4'hD, 0, 0, 32'h1, 0, 0, 0, 0));
        send(mk(4'h4, 1, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0));
        check("full_before_flush", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check("flush_flags_held", 32'(flags_q), 32'b1001);

        // Flush coinciding with s2_load suppresses the flag update
        bus.out_ready = 1'b1;
        send(mk(4'h4, 1, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_s2load_flags", 32'(flags_q), 32'b1001);
        check("flush_s2load_valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with a result held in stage 2
        bus.out_ready = 1'b0;
        send(mk(4'hD, 0, 0, 32'h5, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("pre_rst_result", bus.out_result, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_result", bus.out_result, 32'd0);
        check("arst_out_wr", 32'(bus.out_wr), 32'd0);
        check("arst_flags_q", 32'(flags_q), 32'(FRST));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_off = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(mk(4'hD, 0, 0, 32'h7, 0, 32'h7, 1, FRST));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
